// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and constants for the PWM driver and the PID stage feeding it
package pwm_pkg;
    localparam int DUTY_W = 8;
    localparam logic [DUTY_W-1:0] CNT_MAX = 8'd254;
    typedef enum logic [1:0] {OFF, DEAD, DRIVE_HI, DRIVE_LO} pwm_state_e;
endpackage

// File: rtl/pwm_if.sv
// pwm_if: controller-facing bundle of the PWM driver (enable, duty request, gate drives, strobes)
interface pwm_if;
    import pwm_pkg::*;
    logic              en;
    logic [DUTY_W-1:0] duty;
    logic              pwm_hi;
    logic              pwm_lo;
    logic              period_start;
    logic [DUTY_W-1:0] duty_active;
    modport master (output en, duty, input pwm_hi, pwm_lo, period_start, duty_active);
    modport slave  (input en, duty, output pwm_hi, pwm_lo, period_start, duty_active);
endinterface

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: turns the raw PWM level into a complementary gate pair separated by dead-time
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DEADTIME = 2
)(
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_raw,
    output logic o_pwm_hi,
    output logic o_pwm_lo
);
    localparam logic [7:0] DT = 8'(DEADTIME);
    pwm_state_e r_state;
    pwm_state_e w_state_nx;
    pwm_state_e w_drive;
    logic [7:0] r_dtcnt;
    logic [7:0] w_dtcnt_nx;
    assign w_drive = i_raw ? DRIVE_HI : DRIVE_LO;
    // State register: async reset drops both gates at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= OFF;
            r_dtcnt <= '0;
        end else begin
            r_state <= w_state_nx;
            r_dtcnt <= w_dtcnt_nx;
        end
    end
    // Next state: every change of drive passes through DEAD; the timer is not restarted by raw toggling
    always_comb begin
        w_state_nx = r_state;
        w_dtcnt_nx = r_dtcnt;
        if (!i_en) begin
            w_state_nx = OFF;
            w_dtcnt_nx = '0;
        end else if (r_state == DEAD) begin
            w_state_nx = (r_dtcnt == 8'd1) ? w_drive : DEAD;
            w_dtcnt_nx = r_dtcnt - 8'd1;
        end else if (r_state != w_drive) begin
            w_state_nx = (DT == 8'd0) ? w_drive : DEAD;
            w_dtcnt_nx = DT;
        end
    end
    // Output decode: each gate maps to its own state, so both can never be on together
    always_comb begin
        o_pwm_hi = (r_state == DRIVE_HI);
        o_pwm_lo = (r_state == DRIVE_LO);
    end
endmodule

// File: rtl/pwm_driver.sv
// pwm_driver: 255-tick PWM with double-buffered duty, period strobe and dead-time gate pair
module pwm_driver
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int DEADTIME = 2
)(
    input  logic clk,
    input  logic rst_n,
    pwm_if.slave bus
);
    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);
    logic [15:0]       r_pre;
    logic [DUTY_W-1:0] r_cnt;
    logic [DUTY_W-1:0] r_duty;
    logic              r_en_q;
    logic              r_ps;
    logic              w_run;
    logic              w_tick;
    logic              w_wrap;
    logic              w_load;
    logic              w_raw;
    // The first enabled cycle only loads duty and strobes; counting starts on the next one
    assign w_run  = bus.en & r_en_q;
    assign w_tick = w_run & (r_pre == PRE_MAX);
    assign w_wrap = w_tick & (r_cnt == CNT_MAX);
    assign w_load = bus.en & (w_wrap | ~r_en_q);
    assign w_raw  = r_cnt < r_duty;
    // Prescaler and period counter, both parked at zero while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else begin
            r_pre <= (w_run && !w_tick) ? r_pre + 16'd1 : '0;
            r_cnt <= (!w_run || w_wrap) ? '0 : w_tick ? r_cnt + 8'd1 : r_cnt;
        end
    end
    // Shadow duty and period strobe update only at period boundaries or on enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_q <= 1'b0;
            r_ps   <= 1'b0;
            r_duty <= '0;
        end else begin
            r_en_q <= bus.en;
            r_ps   <= w_load;
            if (w_load) r_duty <= bus.duty;
        end
    end
    assign bus.period_start = r_ps;
    assign bus.duty_active  = r_duty;
    pwm_deadtime #(.DEADTIME(DEADTIME)) u_deadtime (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (bus.en),
        .i_raw    (w_raw),
        .o_pwm_hi (bus.pwm_hi),
        .o_pwm_lo (bus.pwm_lo)
    );
endmodule

// File: tb/tb_pwm_driver.sv
// tb_pwm_driver: randomized duty sequences against a period/window reference model, plus directed corners
module tb_pwm_driver;
    localparam int P1 = 1;
    localparam int L1 = 255 * P1;
    localparam int DT = 2;
    logic clk = 1'b0;
    logic rst_n;
    int n_pass = 0;
    int n_total = 0;
    int d [0:15];
    int wpos [0:15];
    int nper;
    logic obs_hi [0:4095];
    logic obs_lo [0:4095];
    int ps_q [$];
    int hi3;
    int lo3;
    pwm_if if1 ();
    pwm_if if3 ();
    pwm_driver #(.PRESCALE(P1), .DEADTIME(DT)) dut (.clk(clk), .rst_n(rst_n), .bus(if1));
    pwm_driver #(.PRESCALE(3), .DEADTIME(DT)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask
    // Gate pair must never overlap on either instance
    always @(negedge clk) begin
        check("mutex1", 16'(if1.pwm_hi & if1.pwm_lo), 16'd0);
        check("mutex3", 16'(if3.pwm_hi & if3.pwm_lo), 16'd0);
    end
    function automatic bit raw_m(input int c);
        return ((c % L1) / P1) < d[c / L1];
    endfunction
    // A gate is on once raw has held its level for DEADTIME+1 cycles
    function automatic bit drv_m(input int c, input bit lvl);
        if (c < DT) return 1'b0;
        for (int k = c - 1 - DT; k < c; k++)
            if (k >= 0 && raw_m(k) != lvl) return 1'b0;
        return 1'b1;
    endfunction
    // Before the write point the request is noise; from it on, the next period's duty
    function automatic int duty_in(input int c);
        int q = c / L1;
        if (c % L1 >= wpos[q]) return (q + 1 < nper) ? d[q + 1] : d[q];
        return int'($urandom_range(255));
    endfunction
    function automatic int rand_duty();
        int r = int'($urandom_range(9));
        return (r == 0) ? 0 : (r == 1) ? 255 : int'($urandom_range(252, 3));
    endfunction
    function automatic int count(input bit hi, input int from, input int to);
        int n = 0;
        for (int c = from; c <= to; c++) n += int'(hi ? obs_hi[c] : obs_lo[c]);
        return n;
    endfunction
    task automatic run_model(input string tag);
        if1.en = 1'b1;
        if1.duty = 8'(d[0]);
        for (int c = 0; c < nper * L1; c++) begin
            @(posedge clk);
            #1;
            if1.duty = 8'(duty_in(c));
            @(negedge clk);
            obs_hi[c] = if1.pwm_hi;
            obs_lo[c] = if1.pwm_lo;
            check($sformatf("%s_hi@%0d", tag, c), 16'(if1.pwm_hi), 16'(drv_m(c, 1'b1)));
            check($sformatf("%s_lo@%0d", tag, c), 16'(if1.pwm_lo), 16'(drv_m(c, 1'b0)));
            check($sformatf("%s_ps@%0d", tag, c), 16'(if1.period_start), 16'(c % L1 == 0));
            check($sformatf("%s_da@%0d", tag, c), 16'(if1.duty_active), 16'(d[c / L1]));
        end
    endtask
    task automatic pause_en();
        @(posedge clk);
        #1;
        if1.en = 1'b0;
        repeat (3) @(negedge clk);
    endtask
    initial begin
        rst_n = 1'b0;
        if1.en = 1'b1;
        if1.duty = 8'd200;
        if3.en = 1'b0;
        if3.duty = 8'd0;
        repeat (3) begin
            @(negedge clk);
            check("rst_hi", 16'(if1.pwm_hi), 16'd0);
            check("rst_lo", 16'(if1.pwm_lo), 16'd0);
            check("rst_ps", 16'(if1.period_start), 16'd0);
            check("rst_da", 16'(if1.duty_active), 16'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) wpos[i] = int'($urandom_range(L1 - 1, 1));
        nper = 10;
        d[0] = 200; d[1] = 128; d[2] = 128; d[3] = 64; d[4] = 0;
        for (int i = 5; i < 9; i++) d[i] = rand_duty();
        d[9] = 255;
        wpos[2] = 10;
        run_model("A");
        check("steady_hi128", 16'(count(1'b1, 2 * L1, 3 * L1 - 1)), 16'd126);
        check("steady_lo128", 16'(count(1'b0, 2 * L1, 3 * L1 - 1)), 16'd125);
        check("next_hi64", 16'(count(1'b1, 3 * L1, 4 * L1 - 1)), 16'd62);
        @(posedge clk);
        #1;
        if1.en = 1'b0;
        @(negedge clk);
        check("endrop_still_hi", 16'(if1.pwm_hi), 16'd1);
        repeat (3) begin
            @(negedge clk);
            check("endrop_hi", 16'(if1.pwm_hi), 16'd0);
            check("endrop_lo", 16'(if1.pwm_lo), 16'd0);
            check("endrop_ps", 16'(if1.period_start), 16'd0);
            check("endrop_da", 16'(if1.duty_active), 16'd255);
        end
        nper = 2;
        d[0] = 0; d[1] = 255;
        run_model("B");
        check("d0_lo_early", 16'(obs_lo[1]), 16'd0);
        check("d0_lo_at2", 16'(obs_lo[2]), 16'd1);
        check("d0_hi_none", 16'(count(1'b1, 0, L1 - 1)), 16'd0);
        check("d0_lo_cont", 16'(count(1'b0, 0, L1 - 1)), 16'(L1 - 2));
        pause_en();
        nper = 1;
        d[0] = 255;
        run_model("C");
        check("d255_hi_early", 16'(obs_hi[1]), 16'd0);
        check("d255_hi_at2", 16'(obs_hi[2]), 16'd1);
        check("d255_hi_cont", 16'(count(1'b1, 0, L1 - 1)), 16'(L1 - 2));
        check("d255_lo_none", 16'(count(1'b0, 0, L1 - 1)), 16'd0);
        @(posedge clk);
        #3;
        check("pre_rst_hi", 16'(if1.pwm_hi), 16'd1);
        rst_n = 1'b0;
        #1;
        check("arst_hi", 16'(if1.pwm_hi), 16'd0);
        check("arst_lo", 16'(if1.pwm_lo), 16'd0);
        check("arst_ps", 16'(if1.period_start), 16'd0);
        check("arst_da", 16'(if1.duty_active), 16'd0);
        @(negedge clk);
        check("arst_hold_hi", 16'(if1.pwm_hi), 16'd0);
        if1.en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        if3.duty = 8'd10;
        if3.en = 1'b1;
        hi3 = 0;
        lo3 = 0;
        for (int c = 0; c < 3 * 765; c++) begin
            @(negedge clk);
            if (if3.period_start === 1'b1) ps_q.push_back(c);
            if (c >= 765 && c < 1530) begin
                hi3 += int'(if3.pwm_hi);
                lo3 += int'(if3.pwm_lo);
            end
        end
        check("p3_ps_count", 16'(ps_q.size()), 16'd3);
        if (ps_q.size() == 3) begin
            check("p3_first_ps", 16'(ps_q[0]), 16'd0);
            check("p3_spacing1", 16'(ps_q[1] - ps_q[0]), 16'd765);
            check("p3_spacing2", 16'(ps_q[2] - ps_q[1]), 16'd765);
        end
        check("p3_hi", 16'(hi3), 16'd28);
        check("p3_lo", 16'(lo3), 16'd733);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
